// File: rtl/mcycle_pkg.sv
// Shared definitions for the multi-cycle multiplier: state encoding,
// iteration counter width and default operand width.
package mcycle_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W         = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

    // Bit 0 doubles as Busy and bit 1 as Done, so both decode straight from the register.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mcycle_mul_adder32_cla.sv
// 32-bit adder built from eight 4-bit carry-lookahead slices; slice carries
// ripple from one slice to the next.
module adder32_cla (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);

    logic [31:0] gen;
    logic [31:0] prop;
    logic [8:0]  carry;

    assign gen      = a & b;
    assign prop     = a ^ b;
    assign carry[0] = c_in;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_slice
            logic [3:0] sg;
            logic [3:0] sp;
            logic [4:0] c;

            assign sg   = gen[4*gi +: 4];
            assign sp   = prop[4*gi +: 4];
            assign c[0] = carry[gi];

            // Every carry inside the slice is a flat function of the slice carry-in.
            assign c[1] = sg[0] | (sp[0] & c[0]);
            assign c[2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & c[0]);
            assign c[3] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0])
                        | (sp[2] & sp[1] & sp[0] & c[0]);
            assign c[4] = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1])
                        | (sp[3] & sp[2] & sp[1] & sg[0])
                        | (sp[3] & sp[2] & sp[1] & sp[0] & c[0]);

            assign sum[4*gi +: 4] = sp ^ c[3:0];
            assign carry[gi+1]    = c[4];
        end
    endgenerate

    assign c_out = carry[8];

endmodule

// File: rtl/mcycle_mul.sv
// Multi-cycle 32x32->64 shift-and-add multiplier with Start/Busy/Done handshake.
// Signed support is built only when MCYCLE_SIGNED_EN is defined.
module mcycle_mul
    import mcycle_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] result_lo_reg;
    logic [WIDTH-1:0] result_hi_reg;

    logic             accept;
    logic             last_iter;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] shift_acc;
    logic [WIDTH-1:0] shift_mplier;
    logic [WIDTH-1:0] load_mcand;
    logic [WIDTH-1:0] load_mplier;
    logic [WIDTH-1:0] final_lo;
    logic [WIDTH-1:0] final_hi;

    assign accept    = Start && (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign last_iter = (state_reg == ST_RUN) && (count_reg == CNT_LAST);

    // One partial product per cycle: the carry-out becomes the new top bit after the shift.
    assign addend = mplier_reg[0] ? mcand_reg : '0;

    adder32_cla u_acc_add (
        .a     (acc_reg),
        .b     (addend),
        .c_in  (1'b0),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    assign shift_acc    = {add_cout, add_sum[WIDTH-1:1]};
    assign shift_mplier = {add_sum[0], mplier_reg[WIDTH-1:1]};

`ifdef MCYCLE_SIGNED_EN
    logic             sign_reg;
    logic [WIDTH-1:0] neg_op1;
    logic [WIDTH-1:0] neg_op2;
    logic [WIDTH-1:0] neg_lo;
    logic [WIDTH-1:0] neg_hi;
    logic             neg_lo_cout;
    logic             op1_cout_unused;
    logic             op2_cout_unused;
    logic             hi_cout_unused;

    adder32_cla u_neg_op1 (
        .a(~Operand1), .b('0), .c_in(1'b1), .sum(neg_op1), .c_out(op1_cout_unused)
    );
    adder32_cla u_neg_op2 (
        .a(~Operand2), .b('0), .c_in(1'b1), .sum(neg_op2), .c_out(op2_cout_unused)
    );

    // Magnitude of 0x80000000 wraps back to 0x80000000, which is exactly 2^31 unsigned.
    assign load_mcand  = (MCycleOp && Operand1[WIDTH-1]) ? neg_op1 : Operand1;
    assign load_mplier = (MCycleOp && Operand2[WIDTH-1]) ? neg_op2 : Operand2;

    // 64-bit negate of the final shifted product, carry chained from low to high word.
    adder32_cla u_neg_lo (
        .a(~shift_mplier), .b('0), .c_in(1'b1), .sum(neg_lo), .c_out(neg_lo_cout)
    );
    adder32_cla u_neg_hi (
        .a(~shift_acc), .b('0), .c_in(neg_lo_cout), .sum(neg_hi), .c_out(hi_cout_unused)
    );

    assign final_lo = sign_reg ? neg_lo : shift_mplier;
    assign final_hi = sign_reg ? neg_hi : shift_acc;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sign_reg <= 1'b0;
        end else if (accept) begin
            sign_reg <= MCycleOp & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
        end
    end
`else
    logic unused_op;

    assign unused_op   = MCycleOp;
    assign load_mcand  = Operand1;
    assign load_mplier = Operand2;
    assign final_lo    = shift_mplier;
    assign final_hi    = shift_acc;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: state_next = Start ? ST_RUN : ST_IDLE;
            ST_RUN:           if (last_iter) state_next = ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_reg     <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            acc_reg       <= '0;
            result_lo_reg <= '0;
            result_hi_reg <= '0;
        end else if (accept) begin
            mcand_reg  <= load_mcand;
            mplier_reg <= load_mplier;
            acc_reg    <= '0;
            count_reg  <= '0;
        end else if (state_reg == ST_RUN) begin
            acc_reg    <= shift_acc;
            mplier_reg <= shift_mplier;
            count_reg  <= count_reg + CNT_W'(1);
            // Capture on the same edge that enters DONE, so Done and the result coincide.
            if (last_iter) begin
                result_lo_reg <= final_lo;
                result_hi_reg <= final_hi;
            end
        end
    end

    assign Busy    = (state_reg == ST_RUN);
    assign Done    = (state_reg == ST_DONE);
    assign Result1 = result_lo_reg;
    assign Result2 = result_hi_reg;

endmodule

// File: tb/tb_mcycle_mul.sv
// Scoreboard bench for mcycle_mul: expected products are queued at Start and
// checked when Done pulses. Signed vectors run only with MCYCLE_SIGNED_EN.
module tb_mcycle_mul;

`ifdef MCYCLE_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic        CLK;
    logic        RESET;
    logic        Start;
    logic        MCycleOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic        Busy;
    logic        Done;

    int          n_vec;
    int          n_miss;
    logic [63:0] exp_q[$];
    logic [63:0] last_product;

    mcycle_mul #(.WIDTH(32)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                              input logic op);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (op && SIGNED_BUILD) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input int max_cycles, output bit got, output int waited);
        waited = 0;
        while (!Done && waited < max_cycles) begin
            tick();
            waited++;
        end
        got = Done;
    endtask

    // Issues one multiply with a single-cycle Start; returns cycles from drive to Done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                          output bit got, output int lat, output int busy_cnt);
        int w;
        Operand1 = a;
        Operand2 = b;
        MCycleOp = op;
        Start    = 1'b1;
        exp_q.push_back(model_mul(a, b, op));
        busy_cnt = 0;
        tick();
        Start = 1'b0;
        lat   = 1;
        w     = 0;
        while (!Done && w < 40) begin
            if (Busy) busy_cnt++;
            tick();
            w++;
        end
        lat = lat + w;
        got = Done;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        Start = 1'b0;
        MCycleOp = 1'b0;
        Operand1 = 32'hA5A5_A5A5;
        Operand2 = 32'h5A5A_5A5A;
        tick();
        tick();
        RESET = 1'b0;
        n_vec++; if (Busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_vec++; if (Done !== 1'b0) begin n_miss++; $display("FAIL reset_done: got %b want 0", Done); end
        n_vec++; if (Result1 !== 32'h0) begin n_miss++; $display("FAIL reset_r1: got %h want 0", Result1); end
        n_vec++; if (Result2 !== 32'h0) begin n_miss++; $display("FAIL reset_r2: got %h want 0", Result2); end
        tick();
        n_vec++; if (Busy !== 1'b0) begin n_miss++; $display("FAIL idle_busy: got %b want 0", Busy); end
        last_product = 64'h0;
        $display("reset: busy=%b done=%b result=%h_%h", Busy, Done, Result2, Result1);
    endtask

    task automatic check_vectors(input logic [31:0] va[], input logic [31:0] vb[],
                                 input logic vop[], input string tag);
        bit          got;
        int          lat;
        int          bc;
        logic [63:0] e;
        for (int i = 0; i < va.size(); i++) begin
            run_op(va[i], vb[i], vop[i], got, lat, bc);
            e = exp_q.pop_front();
            n_vec++; if (!got) begin n_miss++; $display("FAIL %s_done[%0d]: no Done within bound", tag, i); end
            n_vec++; if (lat != 33) begin n_miss++; $display("FAIL %s_latency[%0d]: got %0d want 33", tag, i, lat); end
            n_vec++; if (bc != 32) begin n_miss++; $display("FAIL %s_busy_cycles[%0d]: got %0d want 32", tag, i, bc); end
            n_vec++; if (Result1 !== e[31:0]) begin n_miss++; $display("FAIL %s_r1[%0d]: got %h want %h", tag, i, Result1, e[31:0]); end
            n_vec++; if (Result2 !== e[63:32]) begin n_miss++; $display("FAIL %s_r2[%0d]: got %h want %h", tag, i, Result2, e[63:32]); end
            n_vec++; if (Busy !== 1'b0) begin n_miss++; $display("FAIL %s_busy_in_done[%0d]: got %b want 0", tag, i, Busy); end
            $display("%s: %h x %h op=%b -> %h_%h (lat %0d)", tag, va[i], vb[i], vop[i], Result2, Result1, lat);
            last_product = e;
            tick();
            n_vec++; if (Done !== 1'b0) begin n_miss++; $display("FAIL %s_done_width[%0d]: got %b want 0", tag, i, Done); end
        end
    endtask

    task automatic test_unsigned();
        logic [31:0] va[];
        logic [31:0] vb[];
        logic        vop[];
        va  = new[10];
        vb  = new[10];
        vop = new[10];
        va[0] = 32'h0000_0003; vb[0] = 32'h0000_0005; vop[0] = 1'b0;
        va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF; vop[1] = 1'b0;
        va[2] = 32'h0000_0000; vb[2] = 32'hDEAD_BEEF; vop[2] = 1'b0;
        va[3] = 32'h0000_0001; vb[3] = 32'hFFFF_FFFF; vop[3] = 1'b0;
        va[4] = 32'h8000_0000; vb[4] = 32'h0000_0002; vop[4] = 1'b0;
        va[5] = 32'h1234_5678; vb[5] = 32'h9ABC_DEF0; vop[5] = 1'b0;
        // Negative-looking operands with MCycleOp=0 must stay unsigned in every build.
        va[6] = 32'hFFFF_FFFE; vb[6] = 32'h0000_0003; vop[6] = 1'b0;
        for (int i = 7; i < 10; i++) begin
            va[i]  = $urandom;
            vb[i]  = $urandom;
            vop[i] = SIGNED_BUILD ? 1'b0 : 1'($urandom_range(0, 1));
        end
        check_vectors(va, vb, vop, "unsigned");
    endtask

    task automatic test_signed();
`ifdef MCYCLE_SIGNED_EN
        logic [31:0] va[];
        logic [31:0] vb[];
        logic        vop[];
        va  = new[7];
        vb  = new[7];
        vop = new[7];
        va[0] = 32'hFFFF_FFFE; vb[0] = 32'h0000_0003; vop[0] = 1'b1;
        va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000; vop[1] = 1'b1;
        va[2] = 32'h7FFF_FFFF; vb[2] = 32'h8000_0000; vop[2] = 1'b1;
        va[3] = 32'hFFFF_FFFF; vb[3] = 32'hFFFF_FFFF; vop[3] = 1'b1;
        va[4] = 32'h0000_0005; vb[4] = 32'hFFFF_FFF9; vop[4] = 1'b1;
        va[5] = 32'h0000_0000; vb[5] = 32'h8000_0000; vop[5] = 1'b1;
        va[6] = $urandom;      vb[6] = $urandom;      vop[6] = 1'b1;
        check_vectors(va, vb, vop, "signed");
`endif
    endtask

    task automatic test_start_ignored();
        bit          got;
        int          w;
        logic [63:0] e;
        Operand1 = 32'h3;
        Operand2 = 32'h5;
        MCycleOp = 1'b0;
        Start    = 1'b1;
        exp_q.push_back(model_mul(32'h3, 32'h5, 1'b0));
        tick();
        Start = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        Operand1 = 32'h7;
        Operand2 = 32'h6;
        Start    = 1'b1;
        n_vec++; if (Result1 !== last_product[31:0]) begin n_miss++; $display("FAIL ignore_hold_r1: got %h want %h", Result1, last_product[31:0]); end
        n_vec++; if (Result2 !== last_product[63:32]) begin n_miss++; $display("FAIL ignore_hold_r2: got %h want %h", Result2, last_product[63:32]); end
        tick();
        Start = 1'b0;
        wait_done(40, got, w);
        e = exp_q.pop_front();
        n_vec++; if (!got || (11 + w) != 33) begin n_miss++; $display("FAIL ignore_latency: got %0d done=%b want 33", 11 + w, got); end
        n_vec++; if (Result1 !== e[31:0]) begin n_miss++; $display("FAIL ignore_r1: got %h want %h", Result1, e[31:0]); end
        n_vec++; if (Result2 !== e[63:32]) begin n_miss++; $display("FAIL ignore_r2: got %h want %h", Result2, e[63:32]); end
        $display("start_ignored: result %h_%h after %0d cycles", Result2, Result1, 11 + w);
        last_product = e;
        tick();
        wait_done(40, got, w);
        n_vec++; if (got) begin n_miss++; $display("FAIL ignore_extra_done: got Done after %0d cycles want none", w); end
    endtask

    task automatic test_reset_mid();
        bit got;
        int w;
        Operand1 = 32'hCAFE_0001;
        Operand2 = 32'h0000_1234;
        MCycleOp = 1'b0;
        Start    = 1'b1;
        exp_q.push_back(model_mul(Operand1, Operand2, 1'b0));
        tick();
        Start = 1'b0;
        repeat (19) @(posedge CLK);
        #1;
        n_vec++; if (Busy !== 1'b1) begin n_miss++; $display("FAIL midreset_pre_busy: got %b want 1", Busy); end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        void'(exp_q.pop_front());
        last_product = 64'h0;
        n_vec++; if (Busy !== 1'b0) begin n_miss++; $display("FAIL midreset_busy: got %b want 0", Busy); end
        n_vec++; if (Done !== 1'b0) begin n_miss++; $display("FAIL midreset_done: got %b want 0", Done); end
        n_vec++; if (Result1 !== 32'h0) begin n_miss++; $display("FAIL midreset_r1: got %h want 0", Result1); end
        n_vec++; if (Result2 !== 32'h0) begin n_miss++; $display("FAIL midreset_r2: got %h want 0", Result2); end
        wait_done(40, got, w);
        n_vec++; if (got) begin n_miss++; $display("FAIL midreset_stray_done: got Done after %0d cycles want none", w); end
        $display("reset_mid: busy=%b result=%h_%h", Busy, Result2, Result1);
    endtask

    task automatic test_back_to_back();
        bit          got;
        int          w;
        logic [63:0] e;
        Operand1 = 32'h1111_1111;
        Operand2 = 32'h0000_0010;
        MCycleOp = 1'b0;
        Start    = 1'b1;
        exp_q.push_back(model_mul(32'h1111_1111, 32'h10, 1'b0));
        tick();
        Operand1 = 32'h7;
        Operand2 = 32'h6;
        exp_q.push_back(model_mul(32'h7, 32'h6, 1'b0));
        wait_done(40, got, w);
        e = exp_q.pop_front();
        n_vec++; if (!got || (1 + w) != 33) begin n_miss++; $display("FAIL b2b_first_latency: got %0d done=%b want 33", 1 + w, got); end
        n_vec++; if ({Result2, Result1} !== e) begin n_miss++; $display("FAIL b2b_first_result: got %h_%h want %h", Result2, Result1, e); end
        $display("back_to_back first: %h_%h", Result2, Result1);
        last_product = e;
        tick();
        Start = 1'b0;
        n_vec++; if (Busy !== 1'b1 || Done !== 1'b0) begin n_miss++; $display("FAIL b2b_restart: got busy=%b done=%b want busy=1 done=0", Busy, Done); end
        repeat (15) @(posedge CLK);
        #1;
        n_vec++; if ({Result2, Result1} !== last_product) begin n_miss++; $display("FAIL b2b_hold: got %h_%h want %h", Result2, Result1, last_product); end
        wait_done(40, got, w);
        e = exp_q.pop_front();
        n_vec++; if (!got || (16 + w) != 33) begin n_miss++; $display("FAIL b2b_interval: got %0d done=%b want 33", 16 + w, got); end
        n_vec++; if (Result1 !== e[31:0]) begin n_miss++; $display("FAIL b2b_second_r1: got %h want %h", Result1, e[31:0]); end
        n_vec++; if (Result2 !== e[63:32]) begin n_miss++; $display("FAIL b2b_second_r2: got %h want %h", Result2, e[63:32]); end
        $display("back_to_back second: %h_%h", Result2, Result1);
        last_product = e;
        tick();
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        RESET  = 1'b1;
        Start  = 1'b0;
        MCycleOp = 1'b0;
        Operand1 = 32'h0;
        Operand2 = 32'h0;
        last_product = 64'h0;
        test_reset();
        test_unsigned();
        test_signed();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        n_vec++; if (exp_q.size() != 0) begin n_miss++; $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
